// File: rtl/text_console.sv
// text_console: character-stream front end for the text-mode screen.
// Accepts 9-bit characters over valid/ready and turns them into single-cycle
// screen writes. It keeps a cursor, handles control codes, wraps lines, rolls
// over to the top row (clearing each new line) and clears the whole screen
// after reset and on form feed.
//
// Ports:
//   clk_sys             system clock
//   reset               synchronous, active-high reset
//   in_data[8:0]        bit 8 = attribute, bits 7:0 = code
//   in_valid/in_ready   input handshake; in_ready is high only while idle
//   char_x/char_y       write cell address
//   char_chr            write character
//   char_str            write strobe, one cycle per cell
//   cursor_x/cursor_y   current cursor position
//   busy                high while a line or screen clear is running
module text_console #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 30,
  parameter logic [8:0]  BLANK = 9'h020
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [8:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [6:0] char_x,
  output logic [5:0] char_y,
  output logic [8:0] char_chr,
  output logic       char_str,
  output logic [6:0] cursor_x,
  output logic [5:0] cursor_y,
  output logic       busy
);

  localparam logic [6:0] LastCol = 7'(COLS - 1);
  localparam logic [5:0] LastRow = 6'(ROWS - 1);

  typedef enum logic [1:0] {StClrAll, StIdle, StClrLine} state_e;

  state_e     r_state, w_state_nxt;
  logic [6:0] r_clr_x, w_clr_x_nxt;
  logic [5:0] r_clr_y, w_clr_y_nxt;
  logic [6:0] r_cur_x, w_cur_x_nxt;
  logic [5:0] r_cur_y, w_cur_y_nxt;
  logic [6:0] r_char_x, w_char_x_nxt;
  logic [5:0] r_char_y, w_char_y_nxt;
  logic [8:0] r_char_chr, w_char_chr_nxt;
  logic       r_char_str, w_char_str_nxt;
  logic       r_in_ready, w_in_ready_nxt;
  logic       r_busy, w_busy_nxt;

  logic       w_accept;
  logic       w_printable;
  logic [5:0] w_row_inc;

  assign w_accept    = in_valid && r_in_ready;
  // The attribute bit forces a code to be drawn even if it is below 0x20.
  assign w_printable = in_data[8] || (in_data[7:0] >= 8'h20);
  // Row roll-over: the bottom row wraps to the top instead of scrolling.
  assign w_row_inc   = (r_cur_y == LastRow) ? 6'd0 : r_cur_y + 6'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_x_nxt    = r_clr_x;
    w_clr_y_nxt    = r_clr_y;
    w_cur_x_nxt    = r_cur_x;
    w_cur_y_nxt    = r_cur_y;
    w_char_x_nxt   = r_char_x;
    w_char_y_nxt   = r_char_y;
    w_char_chr_nxt = r_char_chr;
    w_char_str_nxt = 1'b0;

    unique case (r_state)
      StClrAll: begin
        w_char_str_nxt = 1'b1;
        w_char_x_nxt   = r_clr_x;
        w_char_y_nxt   = r_clr_y;
        w_char_chr_nxt = BLANK;
        if (r_clr_x == LastCol) begin
          w_clr_x_nxt = 7'd0;
          if (r_clr_y == LastRow) begin
            w_clr_y_nxt = 6'd0;
            w_cur_x_nxt = 7'd0;
            w_cur_y_nxt = 6'd0;
            w_state_nxt = StIdle;
          end else begin
            w_clr_y_nxt = r_clr_y + 6'd1;
          end
        end else begin
          w_clr_x_nxt = r_clr_x + 7'd1;
        end
      end

      StIdle: begin
        if (w_accept) begin
          if (w_printable) begin
            w_char_str_nxt = 1'b1;
            w_char_x_nxt   = r_cur_x;
            w_char_y_nxt   = r_cur_y;
            w_char_chr_nxt = in_data;
            if (r_cur_x == LastCol) begin
              w_cur_x_nxt = 7'd0;
              w_cur_y_nxt = w_row_inc;
              w_clr_x_nxt = 7'd0;
              w_state_nxt = StClrLine;
            end else begin
              w_cur_x_nxt = r_cur_x + 7'd1;
            end
          end else begin
            case (in_data[7:0])
              8'h0A: begin
                w_cur_x_nxt = 7'd0;
                w_cur_y_nxt = w_row_inc;
                w_clr_x_nxt = 7'd0;
                w_state_nxt = StClrLine;
              end
              8'h0D: w_cur_x_nxt = 7'd0;
              8'h08: begin
                if (r_cur_x != 7'd0) begin
                  w_cur_x_nxt    = r_cur_x - 7'd1;
                  w_char_str_nxt = 1'b1;
                  w_char_x_nxt   = r_cur_x - 7'd1;
                  w_char_y_nxt   = r_cur_y;
                  w_char_chr_nxt = BLANK;
                end
              end
              8'h0C: begin
                w_clr_x_nxt = 7'd0;
                w_clr_y_nxt = 6'd0;
                w_state_nxt = StClrAll;
              end
              default: ;
            endcase
          end
        end
      end

      StClrLine: begin
        // The cursor row is the freshly entered row and stays fixed here.
        w_char_str_nxt = 1'b1;
        w_char_x_nxt   = r_clr_x;
        w_char_y_nxt   = r_cur_y;
        w_char_chr_nxt = BLANK;
        if (r_clr_x == LastCol) begin
          w_clr_x_nxt = 7'd0;
          w_state_nxt = StIdle;
        end else begin
          w_clr_x_nxt = r_clr_x + 7'd1;
        end
      end

      default: w_state_nxt = StClrAll;
    endcase

    // Handshake/busy are registered from the next state so they line up with it.
    w_in_ready_nxt = (w_state_nxt == StIdle);
    w_busy_nxt     = (w_state_nxt != StIdle);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= StClrAll;
      r_clr_x    <= 7'd0;
      r_clr_y    <= 6'd0;
      r_cur_x    <= 7'd0;
      r_cur_y    <= 6'd0;
      r_char_x   <= 7'd0;
      r_char_y   <= 6'd0;
      r_char_chr <= 9'd0;
      r_char_str <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_x    <= w_clr_x_nxt;
      r_clr_y    <= w_clr_y_nxt;
      r_cur_x    <= w_cur_x_nxt;
      r_cur_y    <= w_cur_y_nxt;
      r_char_x   <= w_char_x_nxt;
      r_char_y   <= w_char_y_nxt;
      r_char_chr <= w_char_chr_nxt;
      r_char_str <= w_char_str_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign in_ready = r_in_ready;
  assign char_x   = r_char_x;
  assign char_y   = r_char_y;
  assign char_chr = r_char_chr;
  assign char_str = r_char_str;
  assign cursor_x = r_cur_x;
  assign cursor_y = r_cur_y;
  assign busy     = r_busy;

endmodule
